// File: rtl/decoder_pkg.sv
// Purpose : shared definitions for the instruction decoder -- opcode
//           constants, execution-class encoding and decoder FSM states.
// Ports   : none (package).
package decoder_pkg;

  // Opcode map: 0-8 ALU, 9-10 MOV, 11-12 LDST, everything above is illegal.
  localparam int unsigned OPC_ADD   = 0;
  localparam int unsigned OPC_SUB   = 1;
  localparam int unsigned OPC_NOT   = 2;
  localparam int unsigned OPC_AND   = 3;
  localparam int unsigned OPC_OR    = 4;
  localparam int unsigned OPC_XOR   = 5;
  localparam int unsigned OPC_XNOR  = 6;
  localparam int unsigned OPC_ADDI  = 7;
  localparam int unsigned OPC_SUBI  = 8;
  localparam int unsigned OPC_MOVI  = 9;
  localparam int unsigned OPC_MOV   = 10;
  localparam int unsigned OPC_LOAD  = 11;
  localparam int unsigned OPC_STORE = 12;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_ALU  = 2'd1,
    CLS_MOV  = 2'd2,
    CLS_LDST = 2'd3
  } op_class_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IDX_I = 2'd1,
    ST_IDX_J = 2'd2,
    ST_ISSUE = 2'd3
  } dec_state_e;

endpackage

// File: rtl/op_class.sv
// Purpose : combinational opcode classifier.
// Ports   : opcode  in  OPC_W  opcode of the held instruction
//           cls     out        execution class (CLS_NONE when illegal)
//           illegal out 1      opcode is not defined
module op_class
  import decoder_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] opcode,
  output op_class_e        cls,
  output logic             illegal
);

  always_comb begin
    cls     = CLS_NONE;
    illegal = 1'b0;
    if (opcode <= OPC_W'(OPC_SUBI)) begin
      cls = CLS_ALU;
    end else if (opcode <= OPC_W'(OPC_MOV)) begin
      cls = CLS_MOV;
    end else if (opcode <= OPC_W'(OPC_STORE)) begin
      cls = CLS_LDST;
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/instr_decode_unit.sv
// Purpose : multi-cycle instruction decoder. Captures one instruction word,
//           presents register index i then j to the register file, then
//           issues a class strobe until the execution unit acknowledges it
//           (or pulses illegal for undefined opcodes).
// Config  : DECODER_IMM_SEXT_EN defined -> immediate (field j) is
//           sign-extended onto bus; undefined -> zero-extended.
// Ports   : clk, reset (async, active-high), flush (sync abort)
//           instr_valid/instr in, instr_ready out (high only in IDLE)
//           opcode, alu_str/mov_str/ldst_str, illegal out
//           unit_ack in (only honoured in ISSUE)
//           idx/idx_valid/idx_sel out (register-file index port)
//           imm_en in, bus out (tri-state immediate bus)
module instr_decode_unit
  import decoder_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 4,
  parameter int IDX_W   = 6,
  parameter int DATA_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic [OPC_W-1:0]   opcode,
  output logic               alu_str,
  output logic               mov_str,
  output logic               ldst_str,
  output logic               illegal,
  input  logic               unit_ack,
  output logic [IDX_W-1:0]   idx,
  output logic               idx_valid,
  output logic               idx_sel,
  input  logic               imm_en,
  output wire  [DATA_W-1:0]  bus
);

  if (INSTR_W < OPC_W + 2*IDX_W) begin : g_chk_instr_w
    $error("INSTR_W too small for opcode plus two index fields");
  end
  if (DATA_W < IDX_W) begin : g_chk_data_w
    $error("DATA_W must be at least IDX_W");
  end

  dec_state_e         state;
  logic [INSTR_W-1:0] held;
  op_class_e          cls;
  logic               cls_illegal;

  wire [IDX_W-1:0] field_i = held[2*IDX_W-1:IDX_W];
  wire [IDX_W-1:0] field_j = held[IDX_W-1:0];

  // Immediate extension of field j to the bus width.
  function automatic logic [DATA_W-1:0] ext_imm(input logic [IDX_W-1:0] f);
    logic [DATA_W-1:0] r;
    r = '0;
    r[IDX_W-1:0] = f;
`ifdef DECODER_IMM_SEXT_EN
    for (int b = IDX_W; b < DATA_W; b++) r[b] = f[IDX_W-1];
`endif
    return r;
  endfunction

  // Classification works on the held opcode so it is stable across IDX_I/IDX_J.
  op_class #(.OPC_W(OPC_W)) u_op_class (
    .opcode  (held[INSTR_W-1 -: OPC_W]),
    .cls     (cls),
    .illegal (cls_illegal)
  );

  assign instr_ready = (state == ST_IDLE);
  assign bus = imm_en ? ext_imm(field_j) : {DATA_W{1'bz}};

  // Index port is a pure decode of the state register and held word, so it
  // is zero whenever the FSM is outside the two index states.
  always_comb begin
    idx       = '0;
    idx_valid = 1'b0;
    idx_sel   = 1'b0;
    case (state)
      ST_IDX_I: begin
        idx       = field_i;
        idx_valid = 1'b1;
      end
      ST_IDX_J: begin
        idx       = field_j;
        idx_valid = 1'b1;
        idx_sel   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      held     <= '0;
      opcode   <= '0;
      alu_str  <= 1'b0;
      mov_str  <= 1'b0;
      ldst_str <= 1'b0;
      illegal  <= 1'b0;
    end else if (flush) begin
      // Flush beats capture and ack in the same cycle.
      state    <= ST_IDLE;
      held     <= '0;
      opcode   <= '0;
      alu_str  <= 1'b0;
      mov_str  <= 1'b0;
      ldst_str <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            held   <= instr;
            opcode <= instr[INSTR_W-1 -: OPC_W];
            state  <= ST_IDX_I;
          end
        end
        ST_IDX_I: state <= ST_IDX_J;
        ST_IDX_J: begin
          alu_str  <= (cls == CLS_ALU);
          mov_str  <= (cls == CLS_MOV);
          ldst_str <= (cls == CLS_LDST);
          illegal  <= cls_illegal;
          state    <= ST_ISSUE;
        end
        ST_ISSUE: begin
          // Illegal is a single-cycle pulse and never waits for an ack.
          if (illegal) begin
            illegal <= 1'b0;
            state   <= ST_IDLE;
          end else if (unit_ack) begin
            alu_str  <= 1'b0;
            mov_str  <= 1'b0;
            ldst_str <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_decode_unit.sv
// Purpose : scoreboard bench for instr_decode_unit. Stimulus pushes the
//           expected index/issue events; a negedge monitor pops and compares
//           every event the decoder presents.
module tb_instr_decode_unit;

  logic        clk = 1'b0;
  logic        reset, flush, instr_valid, unit_ack, imm_en, tb_drv;
  logic [15:0] instr;
  wire         instr_ready, alu_str, mov_str, ldst_str, illegal, idx_valid, idx_sel;
  wire  [3:0]  opcode;
  wire  [5:0]  idx;
  wire  [15:0] bus;

  // Weak-side helper: a second driver shows the DUT has released the bus.
  assign bus = tb_drv ? 16'hA5A5 : 16'hzzzz;

  instr_decode_unit #(.INSTR_W(16), .OPC_W(4), .IDX_W(6), .DATA_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .alu_str     (alu_str),
    .mov_str     (mov_str),
    .ldst_str    (ldst_str),
    .illegal     (illegal),
    .unit_ack    (unit_ack),
    .idx         (idx),
    .idx_valid   (idx_valid),
    .idx_sel     (idx_sel),
    .imm_en      (imm_en),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic        kind;   // 0 = index event, 1 = issue event
    logic [5:0]  idx;
    logic        sel;
    logic [3:0]  cls;    // {illegal, ldst, mov, alu}
    logic [3:0]  opc;
  } ev_t;

  ev_t exp_q[$];
  int  cap;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every index cycle and the first cycle of each strobe/illegal.
  logic prev_act = 1'b0;
  always @(negedge clk) begin
    ev_t  o;
    ev_t  e;
    logic act_now;
    act_now = alu_str | mov_str | ldst_str | illegal;
    if (!reset && (idx_valid || (act_now && !prev_act))) begin
      o.cyc  = 32'(cyc);
      o.kind = !idx_valid;
      o.idx  = idx;
      o.sel  = idx_sel;
      o.cls  = {illegal, ldst_str, mov_str, alu_str};
      o.opc  = opcode;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got 0x%0h, expected none", o);
      end else begin
        e = exp_q.pop_front();
        check("event", 64'(o), 64'(e));
      end
    end
    prev_act <= act_now;
  end

  task automatic start(input logic [15:0] w);
    @(negedge clk);
    check("ready_before_capture", 64'(instr_ready), 64'd1);
    instr       = w;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    cap = cyc;
    exp_q.push_back('{cyc: 32'(cap),     kind: 1'b0, idx: w[11:6], sel: 1'b0, cls: 4'd0, opc: w[15:12]});
    exp_q.push_back('{cyc: 32'(cap + 1), kind: 1'b0, idx: w[5:0],  sel: 1'b1, cls: 4'd0, opc: w[15:12]});
  endtask

  task automatic push_issue(input logic [3:0] cls, input logic [3:0] opc);
    exp_q.push_back('{cyc: 32'(cap + 2), kind: 1'b1, idx: 6'd0, sel: 1'b0, cls: cls, opc: opc});
  endtask

  task automatic finish_issue(input int hold, input logic [3:0] cls);
    int k;
    k = 0;
    while (!(alu_str | mov_str | ldst_str | illegal) && k < 8) begin
      @(negedge clk);
      k++;
    end
    if (k == 8) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: got no strobe, expected class 0x%0h", cls);
      return;
    end
    if (cls[3]) begin
      @(negedge clk);
      check("illegal_one_cycle", 64'({illegal, ldst_str, mov_str, alu_str}), 64'd0);
      check("ready_after_illegal", 64'(instr_ready), 64'd1);
      return;
    end
    for (int h = 0; h < hold; h++) begin
      check("strobe_held", 64'({illegal, ldst_str, mov_str, alu_str}), 64'(cls));
      check("ready_low_in_issue", 64'(instr_ready), 64'd0);
      @(negedge clk);
    end
    unit_ack = 1'b1;
    @(posedge clk);
    #1;
    unit_ack = 1'b0;
    @(negedge clk);
    check("ready_after_ack", 64'(instr_ready), 64'd1);
    check("strobes_after_ack", 64'({illegal, ldst_str, mov_str, alu_str}), 64'd0);
  endtask

  initial begin
    logic [15:0] exp_imm;
    int          k;
`ifdef DECODER_IMM_SEXT_EN
    exp_imm = 16'hFFFF;
`else
    exp_imm = 16'h003F;
`endif
    reset = 1'b1; flush = 1'b0; instr_valid = 1'b0; instr = '0;
    unit_ack = 1'b0; imm_en = 1'b0; tb_drv = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_ready", 64'(instr_ready), 64'd1);
    check("reset_outputs", 64'({opcode, idx, idx_valid, idx_sel, illegal, ldst_str, mov_str, alu_str}), 64'd0);
    imm_en = 1'b1;
    #1;
    check("reset_held_word", 64'(bus), 64'h0);
    imm_en = 1'b0;
    reset  = 1'b0;

    // ADD i=1 j=2, acked after two stalled cycles
    start(16'h0042); push_issue(4'b0001, 4'h0); finish_issue(2, 4'b0001);
    // MOV i=3 j=5, unit held off for five cycles
    start(16'hA0C5); push_issue(4'b0010, 4'hA); finish_issue(5, 4'b0010);
    // opcode 0xF illegal
    start(16'hF1FF); push_issue(4'b1000, 4'hF); finish_issue(0, 4'b1000);
    // XNOR with ack raised early: ignored until ISSUE, taken in first ISSUE cycle
    start(16'h6A95); unit_ack = 1'b1; push_issue(4'b0001, 4'h6); finish_issue(0, 4'b0001);
    // STORE i=0x3F j=0
    start(16'hCFC0); push_issue(4'b0100, 4'hC); finish_issue(1, 4'b0100);
    // opcode 13 illegal with ack held high throughout
    start(16'hD041); unit_ack = 1'b1; push_issue(4'b1000, 4'hD); finish_issue(0, 4'b1000);
    unit_ack = 1'b0;
    // MOVI j=0x3F, then immediate bus checks on the held word
    start(16'h903F); unit_ack = 1'b1; push_issue(4'b0010, 4'h9); finish_issue(0, 4'b0010);
    imm_en = 1'b1;
    #1;
    check("imm_extend", 64'(bus), 64'(exp_imm));
    imm_en = 1'b0; tb_drv = 1'b1;
    #1;
    check("bus_released", 64'(bus), 64'hA5A5);
    tb_drv = 1'b0;

    // LOAD flushed during IDX_J: no strobe, back to IDLE, held word zeroed
    start(16'hB109);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_ready", 64'(instr_ready), 64'd1);
    check("flush_opcode", 64'(opcode), 64'd0);
    imm_en = 1'b1;
    #1;
    check("flush_held_word", 64'(bus), 64'h0);
    imm_en = 1'b0;
    repeat (3) @(negedge clk);
    check("flush_no_ldst", 64'(ldst_str), 64'd0);

    // flush together with instr_valid in IDLE: nothing captured
    @(negedge clk);
    flush = 1'b1; instr_valid = 1'b1; instr = 16'h0042;
    @(posedge clk);
    #1;
    flush = 1'b0; instr_valid = 1'b0;
    @(negedge clk);
    check("flush_no_capture_ready", 64'(instr_ready), 64'd1);
    check("flush_no_capture_opcode", 64'(opcode), 64'd0);

    // reset pulsed while the ALU strobe is waiting for an ack
    start(16'h1041); push_issue(4'b0001, 4'h1);
    k = 0;
    while (!alu_str && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("alu_str_before_reset", 64'(alu_str), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid_issue_outputs",
          64'({opcode, idx, idx_valid, idx_sel, illegal, ldst_str, mov_str, alu_str}), 64'd0);
    check("reset_mid_issue_ready", 64'(instr_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(instr_ready), 64'd1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_decode_unit.md
INSTR_DECODE_UNIT -- requirements
Module: instr_decode_unit

Interface
REQ-001 SHALL have parameter INSTR_W, default 16, instruction width in bits.
REQ-002 SHALL have parameter OPC_W, default 4, opcode field width.
REQ-003 SHALL have parameter IDX_W, default 6, width of each register-index field.
REQ-004 SHALL have parameter DATA_W, default 16, immediate bus width.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, named clk and reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 flush  in  1  synchronous abort of the current instruction (fetch restart).
REQ-009 instr_valid  in  1  instruction word available.
REQ-010 instr  in  INSTR_W  instruction word.
REQ-011 instr_ready  out  1  decoder can accept an instruction.
REQ-012 opcode  out  OPC_W  registered opcode of the held instruction.
REQ-013 alu_str, mov_str, ldst_str  out  1 each  execution-class strobes, one-hot or all zero.
REQ-014 illegal  out  1  one-cycle pulse on an undefined opcode.
REQ-015 unit_ack  in  1  selected execution unit accepted the strobe.
REQ-016 idx  out  IDX_W  register index to register file; idx_valid out 1 qualifies it; idx_sel out 1 (0 = field i, 1 = field j).
REQ-017 imm_en  in  1  drive immediate onto bus; bus  out  DATA_W  tri-state, high-Z when imm_en=0.

Function
REQ-018 Fields of held word: opcode = [INSTR_W-1 -: OPC_W], i = [2*IDX_W-1:IDX_W], j = [IDX_W-1:0].
REQ-019 Opcodes 0-8 (ADD,SUB,NOT,AND,OR,XOR,XNOR,ADDI,SUBI) -> ALU class; 9-10 (MOVI,MOV) -> MOV class; 11-12 (LOAD,STORE) -> LDST class; all others illegal.
REQ-020 FSM states IDLE, IDX_I, IDX_J, ISSUE; instr_ready=1 only in IDLE.
REQ-021 IDLE: instr_valid=1 -> capture instr and opcode into registers, go IDX_I; else stay.
REQ-022 IDX_I: idx=field i, idx_valid=1, idx_sel=0; next IDX_J.
REQ-023 IDX_J: idx=field j, idx_valid=1, idx_sel=1; next ISSUE.
REQ-024 ISSUE, legal opcode: class strobe held high until cycle with unit_ack=1, then IDLE next cycle; ack in the first ISSUE cycle accepted.
REQ-025 ISSUE, illegal opcode: illegal=1 for exactly one cycle, no strobe, return to IDLE regardless of unit_ack.
REQ-026 unit_ack outside ISSUE SHALL be ignored.
REQ-027 Latency: capture at edge N -> idx i valid cycle N+1, idx j N+2, strobe N+3; max throughput one instruction per 4 cycles.
REQ-028 idx_valid=0 and idx=0 outside IDX_I/IDX_J.
REQ-029 flush=1 in any state -> IDLE next edge, strobes, illegal, idx_valid cleared, held word zeroed; flush wins over simultaneous capture and over simultaneous unit_ack.
REQ-030 bus = extended held field j when imm_en=1 (any state), else high-Z.
REQ-031 Elaboration SHALL fail if INSTR_W < OPC_W + 2*IDX_W or DATA_W < IDX_W.

Reset
REQ-032 reset=1 SHALL immediately force IDLE, opcode=0, held word=0, all strobes/illegal/idx_valid/idx/idx_sel=0, instr_ready=1 after release; reset mid-ISSUE drops the strobe without ack.

Configuration
REQ-033 Macro DECODER_IMM_SEXT_EN defined: immediate sign-extended from bit IDX_W-1 to DATA_W.
REQ-034 Macro undefined: immediate zero-extended to DATA_W.

Structure
REQ-035 Package decoder_pkg SHALL hold opcode constants, class encoding and FSM state type.
REQ-036 Combinational sub-module op_class SHALL map opcode to class/illegal; FSM and registers in instr_decode_unit.

Verification
REQ-037 ADD word 0x0042 (i=1, j=2) valid in IDLE -> idx=1 cycle N+1, idx=2 N+2, alu_str=1 N+3, IDLE after ack.
REQ-038 MOV with unit_ack held 0 for 5 cycles -> mov_str stays 1 all 5 cycles, instr_ready=0; ack -> IDLE.
REQ-039 Opcode 0xF -> illegal single-cycle pulse at N+3, no strobes, instr_ready=1 at N+4.
REQ-040 flush asserted in IDX_J of LOAD -> ldst_str never asserts, IDLE next cycle; flush with instr_valid in IDLE -> no capture.
REQ-041 imm_en=1, field j=0x3F -> bus=0xFFFF with DECODER_IMM_SEXT_EN, 0x003F without; imm_en=0 -> bus high-Z.
REQ-042 reset pulsed during ISSUE with alu_str=1 -> all outputs zero immediately, IDLE after release.
